// File: rtl/pcd_miller_encoder_pkg.sv
// Shared types and nominal timing for the ISO/IEC 14443-2A modified-Miller PCD transmitter.
package pcd_miller_encoder_pkg;

   // Shared with the PICC-side sequence decoder; SEQ_ERR is only produced on that side.
   typedef enum logic [1:0] {SEQ_X, SEQ_Y, SEQ_Z, SEQ_ERR} seq_t;

   // fc/128 bit period (106 kbit/s), nominal X pause start and pause length, in carrier clocks.
   localparam int unsigned FC128_BIT_CLKS = 128;
   localparam int unsigned NOM_X_OFFSET   = 64;
   localparam int unsigned NOM_PAUSE_CLKS = 32;

   typedef enum logic [2:0] {
      StIdle,
      StSoc,
      StData,
      StEoc0,
      StEocY
   } enc_state_e;

   // Logic 0 is a Y right after a 1, otherwise a Z.
   function automatic seq_t zero_seq(input logic prev_one);
      return prev_one ? SEQ_Y : SEQ_Z;
   endfunction

endpackage

// File: rtl/pcd_miller_encoder_if.sv
// Bit-stream valid/ready handshake into the Miller encoder.
interface pcd_miller_encoder_if;

   logic in_valid;
   logic in_data;
   logic in_last;
   logic in_ready;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/pcd_miller_encoder.sv
// Reader-side ISO/IEC 14443-2A modified-Miller transmitter: SOC, data bits and EOC
// encoded as Z/X/Y pause sequences on pause_n_o.
module pcd_miller_encoder
   import pcd_miller_encoder_pkg::*;
#(
   parameter int unsigned BIT_CLKS   = FC128_BIT_CLKS,
   parameter int unsigned X_OFFSET   = NOM_X_OFFSET,
   parameter int unsigned PAUSE_CLKS = NOM_PAUSE_CLKS
) (
   input  logic                     clk,
   input  logic                     rst_n,
   pcd_miller_encoder_if.slave      in_if,
   output logic                     pause_n_o,
   output logic                     busy_o,
   output logic                     underflow_o
);

   localparam int unsigned CntW = $clog2(BIT_CLKS);

   localparam logic [CntW-1:0] CntLast = CntW'(BIT_CLKS - 1);
   // One extra bit so an X pause ending exactly at BIT_CLKS does not wrap.
   localparam logic [CntW:0] PauseEnd = (CntW + 1)'(PAUSE_CLKS);
   localparam logic [CntW:0] XStart   = (CntW + 1)'(X_OFFSET);
   localparam logic [CntW:0] XEnd     = (CntW + 1)'(X_OFFSET + PAUSE_CLKS);

   if (!(PAUSE_CLKS > 0 && PAUSE_CLKS <= X_OFFSET && X_OFFSET < BIT_CLKS)) begin : g_bad_params
      $error("pcd_miller_encoder: need 0 < PAUSE_CLKS <= X_OFFSET < BIT_CLKS");
   end

   enc_state_e      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   seq_t            cur_seq_q, cur_seq_d;
   logic            prev_one_q, prev_one_d;
   logic            last_seen_q, last_seen_d;
   logic            pause_n_q, pause_n_d;
   logic            busy_q, busy_d;
   logic            in_ready;
   logic            underflow;
   logic            cnt_wrap;
   logic [CntW:0]   cnt_ext_d;

   assign cnt_wrap = (cnt_q == CntLast);

   // Next-state: sequence sequencing, bit acceptance and frame termination.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cur_seq_d   = cur_seq_q;
      prev_one_d  = prev_one_q;
      last_seen_d = last_seen_q;
      in_ready    = 1'b0;
      underflow   = 1'b0;

      case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (in_if.in_valid) begin
               state_d     = StSoc;
               cur_seq_d   = SEQ_Z;
               prev_one_d  = 1'b0;
               last_seen_d = 1'b0;
            end
         end

         StSoc, StData: begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_wrap) begin
               if (!last_seen_q) begin
                  in_ready = 1'b1;
               end
               if (!last_seen_q && in_if.in_valid) begin
                  state_d     = StData;
                  cur_seq_d   = in_if.in_data ? SEQ_X : zero_seq(prev_one_q);
                  prev_one_d  = in_if.in_data;
                  last_seen_d = in_if.in_last;
               end else begin
                  // Frame done, or starved: close the frame with a legal EOC either way.
                  underflow  = !last_seen_q;
                  state_d    = StEoc0;
                  cur_seq_d  = zero_seq(prev_one_q);
                  prev_one_d = 1'b0;
               end
            end
         end

         StEoc0: begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_wrap) begin
               state_d   = StEocY;
               cur_seq_d = SEQ_Y;
            end
         end

         StEocY: begin
            cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
            if (cnt_wrap) begin
               state_d   = StIdle;
               cur_seq_d = SEQ_Y;
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Output pattern computed from the next state so pause_n and busy line up with state_q.
   always_comb begin
      pause_n_d = 1'b1;
      cnt_ext_d = {1'b0, cnt_d};
      busy_d    = (state_d != StIdle);
      if (state_d != StIdle) begin
         case (cur_seq_d)
            SEQ_Z:   pause_n_d = !(cnt_ext_d < PauseEnd);
            SEQ_X:   pause_n_d = !(cnt_ext_d >= XStart && cnt_ext_d < XEnd);
            default: pause_n_d = 1'b1;
         endcase
      end
   end

   // State and registered outputs; reset returns the carrier to unmodulated at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         cur_seq_q   <= SEQ_Y;
         prev_one_q  <= 1'b0;
         last_seen_q <= 1'b0;
         pause_n_q   <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cur_seq_q   <= cur_seq_d;
         prev_one_q  <= prev_one_d;
         last_seen_q <= last_seen_d;
         pause_n_q   <= pause_n_d;
         busy_q      <= busy_d;
      end
   end

   assign in_if.in_ready = in_ready;
   assign pause_n_o      = pause_n_q;
   assign busy_o         = busy_q;
   assign underflow_o    = underflow;

endmodule

// File: tb/tb_pcd_miller_encoder.sv
// Self-checking bench for pcd_miller_encoder: frame-level reference model plus a
// behavioural Miller decoder for loopback of the captured pause_n waveform.
module tb_pcd_miller_encoder;

   localparam int BitClks   = 128;
   localparam int XOff      = 64;
   localparam int PauseClks = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic pause_n, busy, underflow;

   always #5 clk = ~clk;

   pcd_miller_encoder_if u_if ();

   pcd_miller_encoder u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_if       (u_if),
      .pause_n_o   (pause_n),
      .busy_o      (busy),
      .underflow_o (underflow)
   );

   int  n_cmp = 0;
   int  n_bad = 0;
   int  frame_no = 0;
   bit  frame_bits[$];
   byte exp_seq[$];

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
      end
   endtask

   // Sequence list for a frame of which the first `consumed` bits are accepted.
   function automatic void build_model(input int consumed);
      bit prev = 1'b0;
      exp_seq.delete();
      exp_seq.push_back("Z");
      for (int i = 0; i < consumed; i++) begin
         if (frame_bits[i]) begin
            exp_seq.push_back("X");
            prev = 1'b1;
         end else begin
            exp_seq.push_back(prev ? "Y" : "Z");
            prev = 1'b0;
         end
      end
      exp_seq.push_back(prev ? "Y" : "Z");
      exp_seq.push_back("Y");
   endfunction

   function automatic bit paused(input byte s, input int c);
      return (s == "Z" && c < PauseClks) || (s == "X" && c >= XOff && c < XOff + PauseClks);
   endfunction

   // Entered #1 after a posedge. skip_idle: the previous frame already started this one.
   task automatic run_frame(input int consumed, input bit uf, input bit skip_idle,
                            input bit hold_end);
      int   total;
      logic cap[$];
      byte  sym;
      bit   dec[$];
      bit   prev_x;
      build_model(consumed);
      total = exp_seq.size() * BitClks;
      frame_no++;
      for (int t = skip_idle ? 0 : -1; t <= total; t++) begin
         int k;
         int c;
         bit hs;
         bit ufc;
         k   = (t < 0) ? 0 : t / BitClks;
         c   = (t < 0) ? 0 : t % BitClks;
         hs  = (t >= 0 && t < total && c == BitClks - 1 && k < consumed);
         ufc = (uf && t >= 0 && t < total && c == BitClks - 1 && k == consumed);
         u_if.in_data = 1'($urandom);
         u_if.in_last = 1'($urandom);
         if (t < 0) begin
            u_if.in_valid = 1'b1;
         end else if (t == total) begin
            u_if.in_valid = hold_end;
         end else if (hs) begin
            u_if.in_valid = 1'b1;
            u_if.in_data  = frame_bits[k];
            u_if.in_last  = (!uf && k == consumed - 1);
         end else if (ufc) begin
            u_if.in_valid = 1'b0;
         end else begin
            u_if.in_valid = 1'($urandom);
         end
         @(negedge clk);
         if (t >= 0 && t < total) begin
            check_eq($sformatf("f%0d t%0d pause_n", frame_no, t), pause_n,
                     !paused(exp_seq[k], c));
            check_eq($sformatf("f%0d t%0d busy", frame_no, t), busy, 1);
            check_eq($sformatf("f%0d t%0d in_ready", frame_no, t), u_if.in_ready, hs || ufc);
            check_eq($sformatf("f%0d t%0d underflow", frame_no, t), underflow, ufc);
            cap.push_back(pause_n);
         end else begin
            check_eq($sformatf("f%0d idle t%0d pause_n", frame_no, t), pause_n, 1);
            check_eq($sformatf("f%0d idle t%0d busy", frame_no, t), busy, 0);
            check_eq($sformatf("f%0d idle t%0d in_ready", frame_no, t), u_if.in_ready, 0);
         end
         @(posedge clk);
         #1;
      end
      // Loopback: classify each bit period of the captured waveform and Miller-decode it.
      prev_x = 1'b0;
      for (int k = 0; k < exp_seq.size(); k++) begin
         int lz = 0;
         int lx = 0;
         int lo = 0;
         for (int c = 0; c < BitClks; c++) begin
            if (cap[k * BitClks + c] !== 1'b1) begin
               if (c < PauseClks) lz++;
               else if (c >= XOff && c < XOff + PauseClks) lx++;
               else lo++;
            end
         end
         if (lo == 0 && lz == PauseClks && lx == 0) sym = "Z";
         else if (lo == 0 && lz == 0 && lx == PauseClks) sym = "X";
         else if (lo == 0 && lz == 0 && lx == 0) sym = "Y";
         else sym = "?";
         check_eq($sformatf("f%0d seq%0d", frame_no, k), sym, exp_seq[k]);
         if (k > 0 && dec.size() <= consumed + 1 && !(sym == "Y" && !prev_x)) begin
            dec.push_back(sym == "X");
            prev_x = (sym == "X");
         end else if (k > 0) begin
            break;
         end
      end
      if (dec.size() > 0) void'(dec.pop_back());
      check_eq($sformatf("f%0d decoded length", frame_no), dec.size(), consumed);
      for (int i = 0; i < consumed && i < dec.size(); i++) begin
         check_eq($sformatf("f%0d decoded bit%0d", frame_no, i), dec[i], frame_bits[i]);
      end
   endtask

   task automatic random_bits(input int n);
      frame_bits.delete();
      for (int i = 0; i < n; i++) frame_bits.push_back(1'($urandom));
   endtask

   initial begin
      u_if.in_valid = 1'b0;
      u_if.in_data  = 1'b0;
      u_if.in_last  = 1'b0;
      #12;
      check_eq("reset pause_n", pause_n, 1);
      check_eq("reset busy", busy, 0);
      check_eq("reset in_ready", u_if.in_ready, 0);
      check_eq("reset underflow", underflow, 0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;

      frame_bits = '{1'b1};
      run_frame(1, 1'b0, 1'b0, 1'b0);
      frame_bits = '{1'b0, 1'b0};
      run_frame(2, 1'b0, 1'b0, 1'b0);
      frame_bits = '{1'b0, 1'b1, 1'b1, 1'b0};
      run_frame(4, 1'b0, 1'b0, 1'b0);
      // Starved after one bit, then starved right after SOC.
      frame_bits = '{1'b1};
      run_frame(1, 1'b1, 1'b0, 1'b0);
      frame_bits.delete();
      run_frame(0, 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of an X pause.
      u_if.in_valid = 1'b1;
      @(posedge clk);
      #1 u_if.in_valid = 1'b0;
      repeat (BitClks - 1) @(posedge clk);
      #1;
      u_if.in_valid = 1'b1;
      u_if.in_data  = 1'b1;
      u_if.in_last  = 1'b0;
      @(posedge clk);
      #1 u_if.in_valid = 1'b0;
      repeat (XOff + 6) @(posedge clk);
      @(negedge clk);
      check_eq("pre-reset pause_n", pause_n, 0);
      check_eq("pre-reset busy", busy, 1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("mid-frame reset pause_n", pause_n, 1);
      check_eq("mid-frame reset busy", busy, 0);
      check_eq("mid-frame reset in_ready", u_if.in_ready, 0);
      check_eq("mid-frame reset underflow", underflow, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      frame_bits = '{1'b1, 1'b0, 1'b1};
      run_frame(3, 1'b0, 1'b0, 1'b0);

      // Back-to-back frames with in_valid held through the idle cycle.
      random_bits(5);
      run_frame(5, 1'b0, 1'b0, 1'b1);
      random_bits(4);
      run_frame(4, 1'b0, 1'b1, 1'b0);

      for (int f = 0; f < 6; f++) begin
         int n;
         bit uf;
         n  = $urandom_range(1, 12);
         uf = ($urandom_range(0, 3) == 0);
         random_bits(n);
         run_frame(uf ? $urandom_range(0, n) : n, uf, 1'b0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Hard time limit so a broken design can never hang the run.
   initial begin
      #2_000_000;
      $display("FAIL timeout: observed no end expected end");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "timeout");
   end

endmodule
